// File: rtl/channel_buffer.sv
// Channel model FIFO: flips one rotating bit of each symbol accepted while noise is high.
// Latency: 1 cycle from accept to head of an empty FIFO (first-word-fall-through).
// Backpressure: in_ready_sig drops when full, with no write-through on a same-cycle pop.
//
// Ports:
//   clk_sig, reset_sig        : clock, asynchronous active-high reset
//   noise_sig                 : corrupt the symbol accepted this cycle
//   in_valid/in_data/in_ready : upstream symbol handshake (encoder side)
//   out_valid/out_data/out_ready : downstream handshake (decoder side)
//   sym_cnt_sig, err_cnt_sig  : saturating counts of accepted / corrupted symbols
module channel_buffer #(
  parameter int CODE_W = 2,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk_sig,
  input  logic              reset_sig,
  input  logic              noise_sig,
  input  logic              in_valid_sig,
  input  logic [CODE_W-1:0] in_data_sig,
  output logic              in_ready_sig,
  output logic              out_valid_sig,
  output logic [CODE_W-1:0] out_data_sig,
  input  logic              out_ready_sig,
  output logic [CNT_W-1:0]  sym_cnt_sig,
  output logic [CNT_W-1:0]  err_cnt_sig
);

  localparam int AW    = $clog2(DEPTH);
  localparam int SEL_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       occ_q, occ_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [CNT_W-1:0]  sym_cnt_q, sym_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  // Storage holds no control state, so it is left unreset.
  logic [CODE_W-1:0] mem_q [DEPTH];

  logic              full;
  logic              empty;
  logic              accept;
  logic              pop;
  logic [CODE_W-1:0] flip_mask;
  logic [CODE_W-1:0] wr_dat;

  assign full          = (occ_q == (AW+1)'(DEPTH));
  assign empty         = (occ_q == '0);
  assign in_ready_sig  = !full;
  assign out_valid_sig = !empty;
  assign accept        = in_valid_sig && in_ready_sig;
  assign pop           = out_valid_sig && out_ready_sig;

  // One-hot flip of the currently selected bit; zero when the channel is quiet.
  always_comb begin
    flip_mask = '0;
    for (int i = 0; i < CODE_W; i++) begin
      flip_mask[i] = noise_sig && (sel_q == SEL_W'(i));
    end
  end

  assign wr_dat       = in_data_sig ^ flip_mask;
  assign out_data_sig = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    sel_d     = sel_q;
    sym_cnt_d = sym_cnt_q;
    err_cnt_d = err_cnt_q;

    if (accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (sym_cnt_q != '1) sym_cnt_d = sym_cnt_q + 1'b1;
      if (noise_sig) begin
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
        sel_d = (sel_q == SEL_W'(CODE_W-1)) ? '0 : sel_q + 1'b1;
      end
    end

    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    // Simultaneous accept and pop leaves occupancy untouched.
    if (accept && !pop)      occ_d = occ_q + 1'b1;
    else if (pop && !accept) occ_d = occ_q - 1'b1;
  end

  always_ff @(posedge clk_sig or posedge reset_sig) begin
    if (reset_sig) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      sel_q     <= '0;
      sym_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      sel_q     <= sel_d;
      sym_cnt_q <= sym_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_ff @(posedge clk_sig) begin
    if (accept) mem_q[wr_ptr_q] <= wr_dat;
  end

  assign sym_cnt_sig = sym_cnt_q;
  assign err_cnt_sig = err_cnt_q;

endmodule

// File: tb/tb_channel_buffer.sv
// Bench for channel_buffer: directed scenarios followed by random traffic,
// all checked against a queue-based model of the corrupting FIFO.
module tb_channel_buffer;

  localparam int CODE_W = 2;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              rst;
  logic              noise;
  logic              in_valid;
  logic [CODE_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [CODE_W-1:0] out_data;
  logic              out_ready;
  logic [CNT_W-1:0]  sym_cnt;
  logic [CNT_W-1:0]  err_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [CODE_W-1:0] exp_q[$];
  int                m_sel = 0;
  int                m_sym = 0;
  int                m_err = 0;

  channel_buffer #(.CODE_W(CODE_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_sig      (clk),
    .reset_sig    (rst),
    .noise_sig    (noise),
    .in_valid_sig (in_valid),
    .in_data_sig  (in_data),
    .in_ready_sig (in_ready),
    .out_valid_sig(out_valid),
    .out_data_sig (out_data),
    .out_ready_sig(out_ready),
    .sym_cnt_sig  (sym_cnt),
    .err_cnt_sig  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : v;
  endfunction

  // One clock cycle: drive inputs, check DUT against the model mid-cycle,
  // then advance the model across the rising edge.
  task automatic step(input logic v, input logic [CODE_W-1:0] d, input logic n, input logic r);
    bit               exp_rdy;
    bit               exp_vld;
    bit               acc;
    bit               pp;
    logic [CODE_W-1:0] flipped;
    in_valid  = v;
    in_data   = d;
    noise     = n;
    out_ready = r;
    exp_rdy   = (exp_q.size() < DEPTH);
    exp_vld   = (exp_q.size() > 0);
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(exp_vld));
    if (exp_vld) chk("out_data", 32'(out_data), 32'(exp_q[0]));
    chk("sym_cnt", 32'(sym_cnt), 32'(sat(m_sym)));
    chk("err_cnt", 32'(err_cnt), 32'(sat(m_err)));
    acc = v && exp_rdy;
    pp  = exp_vld && r;
    @(posedge clk);
    #1;
    if (pp) void'(exp_q.pop_front());
    if (acc) begin
      flipped = d;
      if (n) begin
        flipped[m_sel] = ~flipped[m_sel];
        m_sel = (m_sel + 1) % CODE_W;
        m_err++;
      end
      exp_q.push_back(flipped);
      m_sym++;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_sel = 0;
    m_sym = 0;
    m_err = 0;
  endtask

  initial begin
    int base;
    rst       = 1'b1;
    noise     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();

    // Reset state
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sym_cnt", 32'(sym_cnt), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single clean symbol, visible one cycle after the accepting edge
    step(1'b1, 2'b10, 1'b0, 1'b1);
    chk("first_out_valid", 32'(out_valid), 32'd1);
    chk("first_out_data", 32'(out_data), 32'h2);
    chk("first_sym_cnt", 32'(sym_cnt), 32'd1);
    chk("first_err_cnt", 32'(err_cnt), 32'd0);
    step(1'b0, 2'b00, 1'b1, 1'b1);

    // Three noisy zeros: bit selector rotates 0,1,0
    repeat (3) step(1'b1, 2'b00, 1'b1, 1'b0);
    chk("noisy_err_cnt", 32'(err_cnt), 32'd3);
    chk("noisy_head", 32'(out_data), 32'h1);
    repeat (4) step(1'b0, 2'b00, 1'b0, 1'b1);
    chk("drained_valid", 32'(out_valid), 32'd0);

    // Nine back-to-back writes into a stalled FIFO: the ninth is held
    base = m_sym;
    for (int i = 0; i < 9; i++) step(1'b1, CODE_W'($urandom), 1'b0, 1'b0);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_sym_cnt", 32'(sym_cnt), 32'(base + 8));

    // Full with pop: no write-through this cycle, held symbol enters next cycle
    step(1'b1, 2'b11, 1'b0, 1'b1);
    chk("after_pop_in_ready", 32'(in_ready), 32'd1);
    chk("after_pop_sym_cnt", 32'(sym_cnt), 32'(base + 8));
    step(1'b1, 2'b11, 1'b0, 1'b0);
    chk("held_sym_cnt", 32'(sym_cnt), 32'(base + 9));

    // Half full, then 20 cycles of simultaneous accept and pop
    repeat (4) step(1'b0, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, CODE_W'($urandom), 1'($urandom), 1'b1);
    chk("steady_in_ready", 32'(in_ready), 32'd1);
    chk("steady_out_valid", 32'(out_valid), 32'd1);

    // Five buffered symbols, then an asynchronous reset mid-cycle
    step(1'b1, 2'b01, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_in_ready", 32'(in_ready), 32'd1);
    chk("async_sym_cnt", 32'(sym_cnt), 32'd0);
    chk("async_err_cnt", 32'(err_cnt), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 2'b11, 1'b0, 1'b0);
    chk("post_rst_head", 32'(out_data), 32'h3);
    step(1'b0, 2'b00, 1'b0, 1'b1);
    chk("post_rst_empty", 32'(out_valid), 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), CODE_W'($urandom), 1'($urandom),
           1'($urandom_range(0, 2) != 0));
    end
    repeat (DEPTH + 1) step(1'b0, 2'b00, 1'b0, 1'b1);
    chk("final_empty", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/channel_buffer.md
CHANNEL_BUFFER -- requirements
Module: channel_buffer

Interface
REQ-001 SHALL have parameter CODE_W, default 2, meaning encoded symbol width (rate-1/2 encoder output).
REQ-002 SHALL have parameter DEPTH, default 8, meaning FIFO depth in symbols; it is a power of two and at least 2.
REQ-003 SHALL have parameter CNT_W, default 16, meaning width of the statistics counters.
REQ-004 SHALL have port clk_sig, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_sig, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have port noise_sig, input, 1 bit, channel noise pulse from the noise generator.
REQ-007 SHALL have port in_valid_sig, input, 1 bit, upstream symbol valid.
REQ-008 SHALL have port in_data_sig, input, CODE_W bits, encoded symbol from the encoder.
REQ-009 SHALL have port in_ready_sig, output, 1 bit, block can accept a symbol.
REQ-010 SHALL have port out_valid_sig, output, 1 bit, corrupted symbol available to the decoder.
REQ-011 SHALL have port out_data_sig, output, CODE_W bits, corrupted symbol at the FIFO head.
REQ-012 SHALL have port out_ready_sig, input, 1 bit, decoder accepts the symbol.
REQ-013 SHALL have port sym_cnt_sig, output, CNT_W bits, count of accepted symbols.
REQ-014 SHALL have port err_cnt_sig, output, CNT_W bits, count of injected bit errors.

Function
REQ-015 SHALL define accept as in_valid_sig && in_ready_sig, and pop as out_valid_sig && out_ready_sig.
REQ-016 SHALL drive in_ready_sig = !full and out_valid_sig = !empty, both combinational from the occupancy register only.
REQ-017 SHALL hold a bit-select pointer sel (0..CODE_W-1).
REQ-018 On accept with noise_sig=1, SHALL write in_data_sig with bit sel inverted, then advance sel modulo CODE_W (CODE_W-1 wraps to 0).
REQ-019 On accept with noise_sig=0, SHALL write in_data_sig unmodified and hold sel.
REQ-020 SHALL ignore noise_sig on cycles without accept: no corruption, no sel change, no count.
REQ-021 SHALL implement the FIFO as first-word-fall-through: out_data_sig equals the head entry whenever out_valid_sig=1, and the data is a don't-care when the FIFO is empty.
REQ-022 Write-to-read latency SHALL be 1 cycle: a symbol accepted at edge N is visible on out_data_sig with out_valid_sig=1 after edge N when the FIFO was empty.
REQ-023 SHALL keep read/write pointers of log2(DEPTH) bits that wrap naturally, plus an occupancy count 0..DEPTH.
REQ-024 Simultaneous accept and pop SHALL leave occupancy unchanged; this is legal whenever 0 < occupancy < DEPTH.
REQ-025 When full, in_ready_sig SHALL be 0 even if a pop occurs that cycle (no write-through on full).
REQ-026 When empty, out_valid_sig SHALL be 0; an input accepted that cycle is not bypassed to the output combinationally.
REQ-027 sym_cnt_sig SHALL increment by 1 on each accept and err_cnt_sig by 1 on each accept with noise_sig=1; both saturate at 2^CNT_W-1.
REQ-028 FIFO order SHALL be preserved; no symbol is lost or duplicated under any valid/ready pattern.

Reset
REQ-029 While reset_sig=1, SHALL asynchronously clear the pointers, occupancy, sel, sym_cnt_sig and err_cnt_sig to 0, giving in_ready_sig=1 and out_valid_sig=0.
REQ-030 Reset asserted mid-stream SHALL discard all buffered symbols; after deassertion the first accepted symbol is the first output.
REQ-031 The FIFO storage array SHALL NOT require reset.

Verification
REQ-032 Reset then in_data_sig=2'b10, noise_sig=0, one accept, out_ready_sig=1 -> out_data_sig=2'b10 one cycle later; sym_cnt_sig=1, err_cnt_sig=0.
REQ-033 Three accepts of 2'b00 with noise_sig=1 -> outputs 2'b01, 2'b10, 2'b01 (sel wraps); err_cnt_sig=3.
REQ-034 out_ready_sig=0, 9 back-to-back valid inputs (DEPTH=8) -> in_ready_sig falls after 8 accepts; the 9th is held; sym_cnt_sig=8.
REQ-035 Full FIFO with in_valid_sig=1 and out_ready_sig=1 for one cycle -> one pop, no accept; the next cycle in_ready_sig=1 and the held symbol is accepted.
REQ-036 Half-full FIFO with simultaneous accept and pop for 20 cycles -> occupancy constant, output order matches input order.
REQ-037 reset_sig pulsed asynchronously mid-cycle with 5 symbols buffered -> out_valid_sig=0 and counters=0 immediately, without waiting for a clock edge.
